instruction_sequencer: RTL and testbench

//  Issue side of the 5-bit TPU instruction interface: buffers host instructions, replays them in order to the control unit.

---
 rtl/tpu_isa_pkg.sv | 41 ++++
 rtl/instr_fifo.sv | 57 +++++
 rtl/instruction_sequencer.sv | 133 +++++++++++++
 tb/tb_instruction_sequencer.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tpu_isa_pkg.sv
// Shared TPU instruction-interface definitions: the 5-bit instruction word,
// its field positions, activation encodings and the sequencer FSM states.
package tpu_isa_pkg;

    localparam int unsigned INSTR_W   = 5;
    localparam int unsigned IDX_LW    = 4;
    localparam int unsigned IDX_LI    = 3;
    localparam int unsigned IDX_START = 2;
    localparam int unsigned IDX_ACT   = 0;

    typedef enum logic [1:0] {
        ACT_NONE    = 2'b00,
        ACT_RELU    = 2'b01,
        ACT_SIGMOID = 2'b10,
        ACT_TANH    = 2'b11
    } act_t;

    typedef struct packed {
        logic       load_weights;
        logic       load_inputs;
        logic       nn_start;
        logic [1:0] act;
    } instr_t;

    localparam instr_t NOP = '0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_DONE
    } seq_state_t;

    // Word presented while waiting: everything cleared except the activation select.
    function automatic instr_t hold_act(input instr_t w);
        instr_t r;
        r     = NOP;
        r.act = w.act;
        return r;
    endfunction

endpackage

// File: rtl/instr_fifo.sv
// Synchronous instruction FIFO with occupancy count and synchronous flush.
// Push is dropped when full and pop when empty; no bypass path.
module instr_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 5
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_flush,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [WIDTH-1:0]         i_din,
    output logic [WIDTH-1:0]         o_dout,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == FULL_CNT);
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_dout  = r_mem[r_rd_ptr];

    assign w_push = i_push && !o_full;
    assign w_pop  = i_pop && !o_empty;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push && !i_flush && !i_rst) r_mem[r_wr_ptr] <= i_din;
    end

endmodule

// File: rtl/instruction_sequencer.sv
// Buffers host TPU instructions and replays them in order to the control unit,
// stalling after each nn_start until nn_done. Optional watchdog: SEQ_TIMEOUT_EN.
module instruction_sequencer #(
    parameter int unsigned DEPTH          = 8,
    parameter int unsigned CNT_W          = 16,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [4:0]               in_instr,
    input  logic                     run,
    input  logic                     flush,
    input  logic                     nn_done,
    output logic [4:0]               instr_out,
    output logic                     instr_valid,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   count,
    output logic [CNT_W-1:0]         issue_cnt,
    output logic                     timeout_err
);

    import tpu_isa_pkg::*;

    seq_state_t       r_state;
    seq_state_t       w_next_state;
    instr_t           r_instr_out;
    instr_t           w_next_out;
    instr_t           w_head;
    logic [4:0]       w_head_bits;
    logic             r_instr_valid;
    logic             w_next_valid;
    logic             w_issue;
    logic             w_push;
    logic             w_full;
    logic             w_empty;
    logic             w_timeout_hit;
    logic             w_timeout_err;
    logic [CNT_W-1:0] r_issue_cnt;

    instr_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (INSTR_W)
    ) u_fifo (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_flush (flush),
        .i_push  (w_push),
        .i_pop   (w_issue),
        .i_din   (in_instr),
        .o_dout  (w_head_bits),
        .o_count (count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign w_head      = instr_t'(w_head_bits);
    assign in_ready    = !w_full && !flush;
    assign w_push      = in_valid && in_ready;
    assign instr_out   = r_instr_out;
    assign instr_valid = r_instr_valid;
    assign issue_cnt   = r_issue_cnt;
    assign timeout_err = w_timeout_err;
    assign busy        = (r_state != S_IDLE) || !w_empty;

    always_comb begin
        w_next_state = r_state;
        w_next_out   = NOP;
        w_next_valid = 1'b0;
        w_issue      = 1'b0;
        case (r_state)
            S_IDLE:      if (run && !w_empty && !w_timeout_err) w_issue = 1'b1;
            S_ISSUE:     if (run && !w_empty) w_issue = 1'b1;
                         else w_next_state = S_IDLE;
            S_WAIT_DONE: if (nn_done || w_timeout_hit) w_next_state = S_IDLE;
                         else w_next_out = hold_act(r_instr_out);
            default:     w_next_state = S_IDLE;
        endcase
        // Issue path shared by IDLE and ISSUE; start words divert to WAIT_DONE.
        if (w_issue) begin
            w_next_out   = w_head;
            w_next_valid = 1'b1;
            w_next_state = w_head.nn_start ? S_WAIT_DONE : S_ISSUE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_instr_out   <= NOP;
            r_instr_valid <= 1'b0;
            r_issue_cnt   <= '0;
        end else if (flush) begin
            r_state       <= S_IDLE;
            r_instr_out   <= NOP;
            r_instr_valid <= 1'b0;
        end else begin
            r_state       <= w_next_state;
            r_instr_out   <= w_next_out;
            r_instr_valid <= w_next_valid;
            if (w_issue) r_issue_cnt <= r_issue_cnt + 1'b1;
        end
    end

`ifdef SEQ_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [TW-1:0] LAST_WAIT = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] r_wait_cnt;
    logic          r_timeout_err;

    assign w_timeout_hit = (r_state == S_WAIT_DONE) && !nn_done && (r_wait_cnt == LAST_WAIT);
    assign w_timeout_err = r_timeout_err;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_wait_cnt    <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            if (r_state == S_WAIT_DONE) r_wait_cnt <= r_wait_cnt + 1'b1;
            else                        r_wait_cnt <= '0;
            if (w_timeout_hit) r_timeout_err <= 1'b1;
        end
    end
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT_CYCLES == 0);
    assign w_timeout_hit    = 1'b0;
    assign w_timeout_err    = 1'b0;
`endif

endmodule

// File: tb/tb_instruction_sequencer.sv
// Directed bench for instruction_sequencer: ordering, start/done stall,
// full buffer, flush and (with SEQ_TIMEOUT_EN) the wait watchdog.
module tb_instruction_sequencer;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_instr;
    logic        run;
    logic        flush;
    logic        nn_done;
    logic [4:0]  instr_out;
    logic        instr_valid;
    logic        busy;
    logic [3:0]  count;
    logic [15:0] issue_cnt;
    logic        timeout_err;

    int          n_checks;
    int          n_fail;
    logic [15:0] exp_cnt;

    instruction_sequencer #(
        .DEPTH          (8),
        .CNT_W          (16),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .run         (run),
        .flush       (flush),
        .nn_done     (nn_done),
        .instr_out   (instr_out),
        .instr_valid (instr_valid),
        .busy        (busy),
        .count       (count),
        .issue_cnt   (issue_cnt),
        .timeout_err (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [4:0] t4_word(input int unsigned i);
        logic [2:0] k;
        k = i[2:0];
        return {k[2], k[1], 1'b0, k[0], 1'b1};
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        n_checks++; if (instr_out !== 5'b00000) begin n_fail++; $display("FAIL reset_instr_out: got %b want 00000", instr_out); end
        n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", instr_valid); end
        n_checks++; if (count !== 4'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", count); end
        n_checks++; if (issue_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_issue_cnt: got %0d want 0", issue_cnt); end
        n_checks++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL reset_timeout: got %b want 0", timeout_err); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        rst = 1'b0;
        exp_cnt = 16'd0;
    endtask

    task automatic test_in_order();
        run = 1'b1;
        in_valid = 1'b1;
        in_instr = 5'b10000;
        step();
        in_instr = 5'b01000;
        step();
        n_checks++; if (instr_out !== 5'b10000 || instr_valid !== 1'b1) begin n_fail++; $display("FAIL order_w0: got %b/%b want 10000/1", instr_out, instr_valid); end
        in_instr = 5'b00010;
        step();
        n_checks++; if (instr_out !== 5'b01000 || instr_valid !== 1'b1) begin n_fail++; $display("FAIL order_w1: got %b/%b want 01000/1", instr_out, instr_valid); end
        in_valid = 1'b0;
        step();
        n_checks++; if (instr_out !== 5'b00010 || instr_valid !== 1'b1) begin n_fail++; $display("FAIL order_w2: got %b/%b want 00010/1", instr_out, instr_valid); end
        step();
        exp_cnt = exp_cnt + 16'd3;
        n_checks++; if (instr_out !== 5'b00000 || instr_valid !== 1'b0) begin n_fail++; $display("FAIL order_end: got %b/%b want 00000/0", instr_out, instr_valid); end
        n_checks++; if (issue_cnt !== exp_cnt) begin n_fail++; $display("FAIL order_issue_cnt: got %0d want %0d", issue_cnt, exp_cnt); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL order_busy: got %b want 0", busy); end
    endtask

    task automatic test_wait_done();
        run = 1'b1;
        in_valid = 1'b1;
        in_instr = 5'b00101;
        step();
        // nn_done coincident with the issue edge must be ignored
        in_instr = 5'b10000;
        nn_done = 1'b1;
        step();
        nn_done = 1'b0;
        in_valid = 1'b0;
        n_checks++; if (instr_out !== 5'b00101 || instr_valid !== 1'b1) begin n_fail++; $display("FAIL wait_start: got %b/%b want 00101/1", instr_out, instr_valid); end
        step();
        n_checks++; if (instr_out !== 5'b00001 || instr_valid !== 1'b0) begin n_fail++; $display("FAIL wait_hold: got %b/%b want 00001/0", instr_out, instr_valid); end
        repeat (8) step();
        n_checks++; if (instr_out !== 5'b00001 || count !== 4'd1 || busy !== 1'b1) begin n_fail++; $display("FAIL wait_stall: got out=%b count=%0d busy=%b want 00001/1/1", instr_out, count, busy); end
        nn_done = 1'b1;
        step();
        nn_done = 1'b0;
        n_checks++; if (instr_out !== 5'b00000 || instr_valid !== 1'b0) begin n_fail++; $display("FAIL wait_release: got %b/%b want 00000/0", instr_out, instr_valid); end
        step();
        n_checks++; if (instr_out !== 5'b10000 || instr_valid !== 1'b1) begin n_fail++; $display("FAIL wait_next: got %b/%b want 10000/1", instr_out, instr_valid); end
        step();
        exp_cnt = exp_cnt + 16'd2;
        n_checks++; if (issue_cnt !== exp_cnt || instr_valid !== 1'b0) begin n_fail++; $display("FAIL wait_cnt: got %0d/%b want %0d/0", issue_cnt, instr_valid, exp_cnt); end
    endtask

    task automatic test_full_buffer();
        run = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_instr = t4_word(i);
            step();
        end
        n_checks++; if (count !== 4'd8 || in_ready !== 1'b0) begin n_fail++; $display("FAIL full_state: got count=%0d ready=%b want 8/0", count, in_ready); end
        in_instr = 5'b00000;
        step();
        in_valid = 1'b0;
        n_checks++; if (count !== 4'd8 || instr_valid !== 1'b0) begin n_fail++; $display("FAIL full_drop: got count=%0d valid=%b want 8/0", count, instr_valid); end
        run = 1'b1;
        step();
        n_checks++; if (in_ready !== 1'b1 || count !== 4'd7) begin n_fail++; $display("FAIL full_reopen: got ready=%b count=%0d want 1/7", in_ready, count); end
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (instr_out !== t4_word(i) || instr_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL full_drain[%0d]: got %b/%b want %b/1", i, instr_out, instr_valid, t4_word(i));
            end
            step();
        end
        exp_cnt = exp_cnt + 16'd8;
        n_checks++; if (instr_out !== 5'b00000 || instr_valid !== 1'b0 || count !== 4'd0) begin n_fail++; $display("FAIL full_end: got %b/%b count=%0d want 00000/0/0", instr_out, instr_valid, count); end
        n_checks++; if (issue_cnt !== exp_cnt) begin n_fail++; $display("FAIL full_issue_cnt: got %0d want %0d", issue_cnt, exp_cnt); end
    endtask

    task automatic test_flush();
        run = 1'b1;
        in_valid = 1'b1;
        in_instr = 5'b00110;
        step();
        in_instr = 5'b01000;
        step();
        in_instr = 5'b10001;
        step();
        in_instr = 5'b11010;
        step();
        in_valid = 1'b0;
        exp_cnt = exp_cnt + 16'd1;
        n_checks++; if (count !== 4'd3 || instr_out !== 5'b00010) begin n_fail++; $display("FAIL flush_pre: got count=%0d out=%b want 3/00010", count, instr_out); end
        flush = 1'b1;
        step();
        flush = 1'b0;
        n_checks++; if (count !== 4'd0 || instr_out !== 5'b00000 || instr_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL flush_clear: got count=%0d out=%b valid=%b busy=%b want 0/00000/0/0", count, instr_out, instr_valid, busy); end
        nn_done = 1'b1;
        step();
        nn_done = 1'b0;
        step();
        n_checks++; if (instr_out !== 5'b00000 || instr_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL flush_late_done: got out=%b valid=%b busy=%b want 00000/0/0", instr_out, instr_valid, busy); end
        n_checks++; if (issue_cnt !== exp_cnt) begin n_fail++; $display("FAIL flush_issue_cnt: got %0d want %0d", issue_cnt, exp_cnt); end
    endtask

`ifdef SEQ_TIMEOUT_EN
    task automatic test_timeout();
        run = 1'b1;
        in_valid = 1'b1;
        in_instr = 5'b00100;
        step();
        in_instr = 5'b00001;
        step();
        in_valid = 1'b0;
        exp_cnt = exp_cnt + 16'd1;
        repeat (15) step();
        n_checks++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL tmo_early: got %b want 0", timeout_err); end
        step();
        n_checks++; if (timeout_err !== 1'b1 || instr_out !== 5'b00000) begin n_fail++; $display("FAIL tmo_fire: got err=%b out=%b want 1/00000", timeout_err, instr_out); end
        repeat (3) step();
        n_checks++; if (count !== 4'd1 || instr_valid !== 1'b0 || issue_cnt !== exp_cnt) begin n_fail++; $display("FAIL tmo_no_pop: got count=%0d valid=%b cnt=%0d want 1/0/%0d", count, instr_valid, issue_cnt, exp_cnt); end
        flush = 1'b1;
        step();
        flush = 1'b0;
        n_checks++; if (timeout_err !== 1'b0 || count !== 4'd0 || busy !== 1'b0) begin n_fail++; $display("FAIL tmo_flush: got err=%b count=%0d busy=%b want 0/0/0", timeout_err, count, busy); end
    endtask
`else
    task automatic test_wait_forever();
        run = 1'b1;
        in_valid = 1'b1;
        in_instr = 5'b00100;
        step();
        in_instr = 5'b00001;
        step();
        in_valid = 1'b0;
        exp_cnt = exp_cnt + 16'd1;
        repeat (40) step();
        n_checks++; if (timeout_err !== 1'b0 || busy !== 1'b1 || count !== 4'd1 || instr_valid !== 1'b0) begin n_fail++; $display("FAIL nowd_wait: got err=%b busy=%b count=%0d valid=%b want 0/1/1/0", timeout_err, busy, count, instr_valid); end
        nn_done = 1'b1;
        step();
        nn_done = 1'b0;
        step();
        exp_cnt = exp_cnt + 16'd1;
        n_checks++; if (instr_out !== 5'b00001 || instr_valid !== 1'b1 || issue_cnt !== exp_cnt) begin n_fail++; $display("FAIL nowd_resume: got %b/%b cnt=%0d want 00001/1/%0d", instr_out, instr_valid, issue_cnt, exp_cnt); end
        step();
    endtask
`endif

    initial begin
        n_checks = 0;
        n_fail   = 0;
        exp_cnt  = 16'd0;
        rst      = 1'b0;
        in_valid = 1'b0;
        in_instr = 5'b00000;
        run      = 1'b0;
        flush    = 1'b0;
        nn_done  = 1'b0;
        step();
        test_reset();
        test_in_order();
        test_wait_done();
        test_full_buffer();
        test_flush();
`ifdef SEQ_TIMEOUT_EN
        test_timeout();
`else
        test_wait_forever();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
